// File: rtl/call_return_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | call_return_stack : SAP-2 CALL/RET return-address stack with debug status.
// | Optional macro CALL_STACK_CIRCULAR_EN: push-when-full overwrites oldest.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module call_return_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       call,
  input  logic                       ret,
  input  logic [ADDR_W-1:0]          pc_in,
  input  logic                       clr_err,
  output logic [ADDR_W-1:0]          ret_addr,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full_depth = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W:0]    depth_q, depth_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [PTR_W-1:0]  w_top_idx;
  logic              w_empty;
  logic              w_full;

  assign w_top_idx = head_q - 1'b1;
  assign w_empty   = (depth_q == '0);
  assign w_full    = (depth_q == c_full_depth);

  always_comb begin
    mem_d       = mem_q;
    head_d      = head_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Clear first so an error raised on the same edge takes priority.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    case ({call, ret})
      2'b10: begin
        if (!w_full) begin
          mem_d[head_q] = pc_in;
          head_d        = head_q + 1'b1;
          depth_d       = depth_q + 1'b1;
        end else begin
          overflow_d = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
          mem_d[head_q] = pc_in;
          head_d        = head_q + 1'b1;
`endif
        end
      end
      2'b01: begin
        if (!w_empty) begin
          head_d  = head_q - 1'b1;
          depth_d = depth_q - 1'b1;
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        // Tail-call style replace; on an empty stack this degrades to a push.
        if (!w_empty) begin
          mem_d[w_top_idx] = pc_in;
        end else begin
          mem_d[head_q] = pc_in;
          head_d        = head_q + 1'b1;
          depth_d       = depth_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q      <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ret_addr  = w_empty ? '0 : mem_q[w_top_idx];
  assign depth     = depth_q;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_call_return_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_call_return_stack : self-checking bench for call_return_stack.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_call_return_stack;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc_in;
  logic              clr_err;
  logic [ADDR_W-1:0] ret_addr;
  logic [3:0]        depth;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] model [$];

  call_return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .call     (call),
    .ret      (ret),
    .pc_in    (pc_in),
    .clr_err  (clr_err),
    .ret_addr (ret_addr),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; call = 1'b0; ret = 1'b0; pc_in = '0; clr_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_tests++; if (ret_addr !== 16'h0) begin n_fail++; $display("FAIL reset_ret_addr got=%h exp=0000", ret_addr); end
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    // Asynchronous reset in the middle of a push burst, between clock edges.
    call = 1'b1; pc_in = 16'h5555; tick();
    pc_in = 16'h6666; tick();
    n_tests++; if (depth !== 4'd2) begin n_fail++; $display("FAIL midpush_depth got=%0d exp=2", depth); end
    #3 rst = 1'b1;
    #1;
    n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL async_rst_depth got=%0d exp=0", depth); end
    n_tests++; if (ret_addr !== 16'h0) begin n_fail++; $display("FAIL async_rst_ret_addr got=%h exp=0000", ret_addr); end
    n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    call = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push_pop();
    logic [ADDR_W-1:0] e;
    call = 1'b1;
    pc_in = 16'h1003; tick();
    pc_in = 16'h2005; tick();
    pc_in = 16'h3007; tick();
    call = 1'b0;
    n_tests++; if (depth !== 4'd3) begin n_fail++; $display("FAIL push3_depth got=%0d exp=3", depth); end
    n_tests++; if (ret_addr !== 16'h3007) begin n_fail++; $display("FAIL push3_top got=%h exp=3007", ret_addr); end
    exp_q.push_back(16'h2005);
    exp_q.push_back(16'h1003);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 3; i++) begin
      ret = 1'b1; tick(); ret = 1'b0;
      e = exp_q.pop_front();
      n_tests++; if (ret_addr !== e) begin n_fail++; $display("FAIL pop%0d_top got=%h exp=%h", i, ret_addr, e); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pop3_empty got=%b exp=1", empty); end
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL pop3_errs got ovf=%b unf=%b exp 0 0", overflow, underflow); end
  endtask

  task automatic test_underflow();
    ret = 1'b1; tick(); ret = 1'b0;
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set got=%b exp=1", underflow); end
    n_tests++; if (depth !== 4'd0 || ret_addr !== 16'h0) begin n_fail++; $display("FAIL unf_state got depth=%0d top=%h exp 0 0000", depth, ret_addr); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got=%b exp=0", underflow); end
    ret = 1'b1; clr_err = 1'b1; tick(); ret = 1'b0; clr_err = 1'b0;
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_clr_same_edge got=%b exp=1", underflow); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear2 got=%b exp=0", underflow); end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] e;
    call = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pc_in = 16'h0100 + 16'(i); tick();
    end
    call = 1'b0;
    n_tests++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill8 got full=%b ovf=%b exp 1 0", full, overflow); end
    call = 1'b1; pc_in = 16'h0200; tick(); call = 1'b0;
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got=%b exp=1", full); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    n_tests++; if (depth !== 4'd8) begin n_fail++; $display("FAIL ovf_depth got=%0d exp=8", depth); end
`ifdef CALL_STACK_CIRCULAR_EN
    exp_q.push_back(16'h0200);
    for (int i = 7; i >= 1; i--) exp_q.push_back(16'h0100 + 16'(i));
`else
    for (int i = 7; i >= 0; i--) exp_q.push_back(16'h0100 + 16'(i));
`endif
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (ret_addr !== e) begin n_fail++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, ret_addr, e); end
      ret = 1'b1; tick(); ret = 1'b0;
    end
    n_tests++; if (empty !== 1'b1 || underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_drain got empty=%b unf=%b exp 1 0", empty, underflow); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_replace();
    call = 1'b1;
    pc_in = 16'hAAAA; tick();
    pc_in = 16'hBBBB; tick();
    ret = 1'b1; pc_in = 16'hCCCC; tick();
    call = 1'b0; ret = 1'b0;
    n_tests++; if (depth !== 4'd2) begin n_fail++; $display("FAIL repl_depth got=%0d exp=2", depth); end
    n_tests++; if (ret_addr !== 16'hCCCC) begin n_fail++; $display("FAIL repl_top got=%h exp=cccc", ret_addr); end
    ret = 1'b1; tick(); ret = 1'b0;
    n_tests++; if (ret_addr !== 16'hAAAA) begin n_fail++; $display("FAIL repl_pop got=%h exp=aaaa", ret_addr); end
    ret = 1'b1; tick(); ret = 1'b0;
    call = 1'b1; ret = 1'b1; pc_in = 16'h1234; tick();
    call = 1'b0; ret = 1'b0;
    n_tests++; if (depth !== 4'd1) begin n_fail++; $display("FAIL repl_empty_depth got=%0d exp=1", depth); end
    n_tests++; if (ret_addr !== 16'h1234) begin n_fail++; $display("FAIL repl_empty_top got=%h exp=1234", ret_addr); end
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL repl_empty_unf got=%b exp=0", underflow); end
    ret = 1'b1; tick(); ret = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic c, r, ce, mo, mu;
    logic [ADDR_W-1:0] pc, etop;
    rst = 1'b1; #2; rst = 1'b0;
    model.delete();
    mo = 1'b0; mu = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      c  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 45);
      ce = ($urandom_range(0, 99) < 10);
      pc = 16'($urandom);
      if (ce) begin mo = 1'b0; mu = 1'b0; end
      if (c && !r) begin
        if (model.size() < DEPTH) model.push_back(pc);
        else begin
          mo = 1'b1;
`ifdef CALL_STACK_CIRCULAR_EN
          void'(model.pop_front());
          model.push_back(pc);
`endif
        end
      end else if (r && !c) begin
        if (model.size() > 0) void'(model.pop_back());
        else mu = 1'b1;
      end else if (c && r) begin
        if (model.size() > 0) model[model.size()-1] = pc;
        else model.push_back(pc);
      end
      call = c; ret = r; clr_err = ce; pc_in = pc;
      tick();
      call = 1'b0; ret = 1'b0; clr_err = 1'b0;
      etop = (model.size() > 0) ? model[model.size()-1] : '0;
      n_tests++;
      if (ret_addr !== etop || depth !== 4'(model.size()) || overflow !== mo || underflow !== mu) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d got top=%h depth=%0d ovf=%b unf=%b exp top=%h depth=%0d ovf=%b unf=%b",
                 cyc, ret_addr, depth, overflow, underflow, etop, model.size(), mo, mu);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_replace();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
